y_frame_stats: RTL and testbench

- Sits directly downstream of the RGB-to-luma stage.
- Consumes the 8-bit Y stream with its valid and frame-end strobes, and accumulates per-frame luminance statistics: sum, pixel count, min, max, highlight count and shadow count.
- On each frame end it snapshots the accumulators and computes the rounded mean with a sequential divider.
- The published results feed exposure/HDR-merge control logic.

---
 rtl/y_frame_stats.sv | 211 +++++++++++++++++++++
 tb/tb_y_frame_stats.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y_frame_stats.sv
// y_frame_stats: per-frame luma statistics (sum, count, min, max, highlight and
// shadow counts) with a rounded mean computed by an 8-step restoring divider.
// Results are published together with a one-cycle stat_valid pulse.
module y_frame_stats #(
    parameter int         CNT_W  = 22,
    parameter int         SUM_W  = 30,
    parameter logic [7:0] HI_THR = 8'd250,
    parameter logic [7:0] LO_THR = 8'd5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       Y_in,
    input  logic             valid_in,
    input  logic             frame_end_in,
    output logic             stat_valid,
    output logic [7:0]       y_mean,
    output logic [7:0]       y_min,
    output logic [7:0]       y_max,
    output logic [SUM_W-1:0] y_sum,
    output logic [CNT_W-1:0] pix_cnt,
    output logic [CNT_W-1:0] hi_cnt,
    output logic [CNT_W-1:0] lo_cnt,
    output logic             overrun
);

    // Remainder is one bit wider than the sum so sum + cnt/2 never wraps.
    localparam int REM_W = SUM_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    function automatic logic [7:0] f_min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] f_max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Dividend for round-half-up: sum + floor(cnt/2).
    function automatic logic [REM_W-1:0] f_round_bias(input logic [SUM_W-1:0] sum,
                                                      input logic [CNT_W-1:0] cnt);
        return {1'b0, sum} + {{(REM_W-CNT_W+1){1'b0}}, cnt[CNT_W-1:1]};
    endfunction

    // Accumulators
    logic [CNT_W-1:0] r_cnt, r_hi, r_lo;
    logic [SUM_W-1:0] r_sum;
    logic [7:0]       r_min, r_max;

    // Snapshot and divider
    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_snap_cnt, r_snap_hi, r_snap_lo;
    logic [SUM_W-1:0] r_snap_sum;
    logic [7:0]       r_snap_min, r_snap_max;
    logic [REM_W-1:0] r_rem;
    logic [CNT_W-1:0] r_den;
    logic [7:0]       r_q;
    logic [2:0]       r_bit;

    // Published results
    logic             r_stat_valid, r_overrun;
    logic [7:0]       r_y_mean, r_y_min, r_y_max;
    logic [SUM_W-1:0] r_y_sum;
    logic [CNT_W-1:0] r_pix_cnt, r_hi_cnt, r_lo_cnt;

    // Accumulator next values, including the current pixel if it is taken.
    logic             w_take_px, w_hi_hit, w_lo_hit;
    logic [CNT_W-1:0] w_cnt_nx, w_hi_nx, w_lo_nx;
    logic [SUM_W-1:0] w_sum_nx;
    logic [7:0]       w_min_nx, w_max_nx;

    // Divider step signals
    logic [REM_W-1:0] w_den_sh, w_rem_nx;
    logic             w_sub;
    logic [7:0]       w_q_nx;
    logic             w_last_step, w_snap_load;

    // A saturated counter freezes the whole frame, keeping sum <= 255*cnt.
    assign w_take_px = valid_in && !(&r_cnt);
    assign w_hi_hit  = w_take_px && (Y_in >= HI_THR);
    assign w_lo_hit  = w_take_px && (Y_in <= LO_THR);
    assign w_cnt_nx  = r_cnt + {{(CNT_W-1){1'b0}}, w_take_px};
    assign w_hi_nx   = r_hi + {{(CNT_W-1){1'b0}}, w_hi_hit};
    assign w_lo_nx   = r_lo + {{(CNT_W-1){1'b0}}, w_lo_hit};
    assign w_sum_nx  = r_sum + {{(SUM_W-8){1'b0}}, (w_take_px ? Y_in : 8'd0)};
    assign w_min_nx  = w_take_px ? f_min8(r_min, Y_in) : r_min;
    assign w_max_nx  = w_take_px ? f_max8(r_max, Y_in) : r_max;

    // A zero divisor never subtracts, so an empty frame yields q = 0.
    assign w_den_sh    = {{(REM_W-CNT_W){1'b0}}, r_den} << r_bit;
    assign w_sub       = (r_den != '0) && (r_rem >= w_den_sh);
    assign w_rem_nx    = w_sub ? (r_rem - w_den_sh) : r_rem;
    assign w_q_nx      = r_q | (w_sub ? (8'd1 << r_bit) : 8'd0);
    assign w_last_step = (r_state == S_DIV) && (r_bit == 3'd0);
    assign w_snap_load = (r_state == S_IDLE) && frame_end_in;

    // Accumulate valid pixels; frame end restarts from the reset values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_sum <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_min <= 8'hFF;
            r_max <= 8'h00;
        end else if (frame_end_in) begin
            r_cnt <= '0;
            r_sum <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_min <= 8'hFF;
            r_max <= 8'h00;
        end else begin
            r_cnt <= w_cnt_nx;
            r_sum <= w_sum_nx;
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_min <= w_min_nx;
            r_max <= w_max_nx;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nx;
    end

    // FSM next state: eight divider steps follow each accepted frame end.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (frame_end_in) w_state_nx = S_DIV;
            S_DIV:  if (r_bit == 3'd0) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Snapshot the ending frame and run one restoring division step per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snap_cnt <= '0;
            r_snap_sum <= '0;
            r_snap_hi  <= '0;
            r_snap_lo  <= '0;
            r_snap_min <= '0;
            r_snap_max <= '0;
            r_rem      <= '0;
            r_den      <= '0;
            r_q        <= '0;
            r_bit      <= '0;
        end else if (w_snap_load) begin
            r_snap_cnt <= w_cnt_nx;
            r_snap_sum <= w_sum_nx;
            r_snap_hi  <= w_hi_nx;
            r_snap_lo  <= w_lo_nx;
            // An empty frame reports min 0 rather than the 255 seed.
            r_snap_min <= (w_cnt_nx == '0) ? 8'd0 : w_min_nx;
            r_snap_max <= w_max_nx;
            r_rem      <= f_round_bias(w_sum_nx, w_cnt_nx);
            r_den      <= w_cnt_nx;
            r_q        <= '0;
            r_bit      <= 3'd7;
        end else if (r_state == S_DIV) begin
            r_rem <= w_rem_nx;
            r_q   <= w_q_nx;
            r_bit <= r_bit - 3'd1;
        end
    end

    // Publish results on the final divider step; flag frame ends lost to a busy divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_y_mean     <= '0;
            r_y_min      <= '0;
            r_y_max      <= '0;
            r_y_sum      <= '0;
            r_pix_cnt    <= '0;
            r_hi_cnt     <= '0;
            r_lo_cnt     <= '0;
        end else begin
            r_stat_valid <= w_last_step;
            r_overrun    <= (r_state == S_DIV) && frame_end_in;
            if (w_last_step) begin
                r_y_mean  <= w_q_nx;
                r_y_min   <= r_snap_min;
                r_y_max   <= r_snap_max;
                r_y_sum   <= r_snap_sum;
                r_pix_cnt <= r_snap_cnt;
                r_hi_cnt  <= r_snap_hi;
                r_lo_cnt  <= r_snap_lo;
            end
        end
    end

    assign stat_valid = r_stat_valid;
    assign overrun    = r_overrun;
    assign y_mean     = r_y_mean;
    assign y_min      = r_y_min;
    assign y_max      = r_y_max;
    assign y_sum      = r_y_sum;
    assign pix_cnt    = r_pix_cnt;
    assign hi_cnt     = r_hi_cnt;
    assign lo_cnt     = r_lo_cnt;

endmodule

// File: tb/tb_y_frame_stats.sv
// Testbench for y_frame_stats: directed scenarios plus random frames checked
// against a plain-arithmetic statistics model of each frame's pixel list.
module tb_y_frame_stats;

    localparam int CNT_W = 22;
    localparam int SUM_W = 30;

    typedef struct packed {
        logic [7:0]       mean;
        logic [7:0]       mn;
        logic [7:0]       mx;
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] hi;
        logic [CNT_W-1:0] lo;
    } stats_t;

    typedef struct packed {
        logic       v;
        logic [7:0] y;
        logic       fe;
    } stim_t;

    logic             clk;
    logic             reset_n;
    logic [7:0]       Y_in;
    logic             valid_in;
    logic             frame_end_in;
    logic             stat_valid;
    logic [7:0]       y_mean, y_min, y_max;
    logic [SUM_W-1:0] y_sum;
    logic [CNT_W-1:0] pix_cnt, hi_cnt, lo_cnt;
    logic             overrun;

    int    nvec = 0;
    int    nmis = 0;
    stim_t stim_q[$];

    y_frame_stats #(.CNT_W(CNT_W), .SUM_W(SUM_W), .HI_THR(8'd250), .LO_THR(8'd5)) dut (
        .clk(clk), .reset_n(reset_n), .Y_in(Y_in), .valid_in(valid_in),
        .frame_end_in(frame_end_in), .stat_valid(stat_valid), .y_mean(y_mean),
        .y_min(y_min), .y_max(y_max), .y_sum(y_sum), .pix_cnt(pix_cnt),
        .hi_cnt(hi_cnt), .lo_cnt(lo_cnt), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input stats_t s);
        return $sformatf("mean=%0d min=%0d max=%0d sum=%0d cnt=%0d hi=%0d lo=%0d",
                         s.mean, s.mn, s.mx, s.sum, s.cnt, s.hi, s.lo);
    endfunction

    function automatic stats_t cur();
        stats_t s;
        s.mean = y_mean; s.mn = y_min; s.mx = y_max; s.sum = y_sum;
        s.cnt = pix_cnt; s.hi = hi_cnt; s.lo = lo_cnt;
        return s;
    endfunction

    // Reference: statistics of a frame straight from its list of pixels.
    function automatic stats_t model(input logic [7:0] px[$]);
        stats_t s;
        longint sum = 0;
        longint n;
        int mn = 255, mx = 0, hi = 0, lo = 0;
        s = '0;
        n = px.size();
        if (n == 0) return s;
        foreach (px[k]) begin
            sum += px[k];
            if (px[k] < mn) mn = px[k];
            if (px[k] > mx) mx = px[k];
            if (px[k] >= 250) hi++;
            if (px[k] <= 5) lo++;
        end
        s.mean = 8'((sum + n / 2) / n);
        s.mn   = 8'(mn);
        s.mx   = 8'(mx);
        s.sum  = SUM_W'(sum);
        s.cnt  = CNT_W'(n);
        s.hi   = CNT_W'(hi);
        s.lo   = CNT_W'(lo);
        return s;
    endfunction

    // Apply one cycle of inputs; return 1 time unit after the active edge.
    task automatic drive(input logic v, input logic [7:0] y, input logic fe);
        valid_in = v; Y_in = y; frame_end_in = fe;
        @(posedge clk);
        #1;
    endtask

    // Called right after the frame-end cycle (cycle 0): samples cycles 1..ncyc,
    // applying queued stimulus then idle, and records stat_valid/overrun events.
    task automatic observe(input int ncyc, output int npulse, output int vlat,
                           output stats_t got, output int novr, output int olat);
        stim_t st;
        npulse = 0; vlat = -1; got = '0; novr = 0; olat = -1;
        for (int j = 0; j < ncyc; j++) begin
            if (stat_valid === 1'b1) begin
                if (npulse == 0) begin vlat = j + 1; got = cur(); end
                npulse++;
            end
            if (overrun === 1'b1) begin
                if (novr == 0) olat = j + 1;
                novr++;
            end
            if (stim_q.size() > 0) begin
                st = stim_q.pop_front();
                drive(st.v, st.y, st.fe);
            end else begin
                drive(1'b0, 8'd0, 1'b0);
            end
        end
    endtask

    // Drive a frame with random valid gaps; frame end either on the last pixel or alone.
    task automatic send_frame(input logic [7:0] px[$], input bit coincident);
        for (int k = 0; k < px.size(); k++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) drive(1'b0, 8'($urandom), 1'b0);
            drive(1'b1, px[k], (coincident && k == px.size() - 1) ? 1'b1 : 1'b0);
        end
        if (!(coincident && px.size() > 0)) drive(1'b0, 8'($urandom), 1'b1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; valid_in = 1'b0; Y_in = '0; frame_end_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if (cur() !== stats_t'('0) || stat_valid !== 1'b0 || overrun !== 1'b0) begin
            nmis++;
            $display("FAIL reset_outputs: got %s sv=%b ovr=%b, required all 0", fmt(cur()), stat_valid, overrun);
        end
        reset_n = 1'b1;
        drive(1'b0, 8'd0, 1'b0);
    endtask

    task automatic test_basic();
        int np, vl, no, ol;
        stats_t got, exp;
        logic [7:0] px[$] = '{8'd10, 8'd20, 8'd30, 8'd41};
        exp = model(px);
        drive(1'b1, 8'd10, 1'b0); drive(1'b1, 8'd20, 1'b0); drive(1'b1, 8'd30, 1'b0);
        drive(1'b1, 8'd41, 1'b1);
        observe(12, np, vl, got, no, ol);
        nvec++;
        if (np !== 1 || vl !== 9) begin
            nmis++; $display("FAIL basic_timing: got pulses=%0d at cycle %0d, required 1 at cycle 9", np, vl);
        end
        nvec++;
        if (got !== exp || exp.mean !== 8'd25 || exp.sum !== 30'd101) begin
            nmis++; $display("FAIL basic_stats: got %s, required %s", fmt(got), fmt(exp));
        end
        nvec++;
        if (no !== 0) begin nmis++; $display("FAIL basic_no_overrun: got %0d overruns, required 0", no); end
        nvec++;
        if (cur() !== exp) begin nmis++; $display("FAIL basic_hold: got %s, required %s", fmt(cur()), fmt(exp)); end
    endtask

    task automatic test_gaps();
        int np, vl, no, ol;
        stats_t got, exp;
        exp = '0; exp.mean = 8'd2; exp.mn = 8'd1; exp.mx = 8'd2; exp.sum = 30'd3;
        exp.cnt = 22'd2; exp.hi = 22'd0; exp.lo = 22'd2;
        drive(1'b1, 8'd1, 1'b0); drive(1'b0, 8'd99, 1'b0); drive(1'b0, 8'd77, 1'b0);
        drive(1'b1, 8'd2, 1'b0); drive(1'b0, 8'd33, 1'b0); drive(1'b0, 8'd44, 1'b1);
        observe(12, np, vl, got, no, ol);
        nvec++;
        if (np !== 1 || vl !== 9 || got !== exp) begin
            nmis++; $display("FAIL gaps_round: got %s (pulses=%0d cyc=%0d), required %s at cycle 9", fmt(got), np, vl, fmt(exp));
        end
    endtask

    task automatic test_bright_then_empty();
        int np, vl, no, ol;
        stats_t got, exp;
        exp = '0; exp.mean = 8'd255; exp.mn = 8'd255; exp.mx = 8'd255; exp.sum = 30'd765;
        exp.cnt = 22'd3; exp.hi = 22'd3; exp.lo = 22'd0;
        drive(1'b1, 8'd255, 1'b0); drive(1'b1, 8'd255, 1'b0); drive(1'b1, 8'd255, 1'b1);
        observe(12, np, vl, got, no, ol);
        nvec++;
        if (np !== 1 || vl !== 9 || got !== exp) begin
            nmis++; $display("FAIL bright: got %s (pulses=%0d cyc=%0d), required %s at cycle 9", fmt(got), np, vl, fmt(exp));
        end
        drive(1'b0, 8'd0, 1'b1);
        observe(12, np, vl, got, no, ol);
        nvec++;
        if (np !== 1 || vl !== 9 || got !== stats_t'('0)) begin
            nmis++; $display("FAIL empty_frame: got %s (pulses=%0d cyc=%0d), required all 0 at cycle 9", fmt(got), np, vl);
        end
    endtask

    task automatic test_overrun();
        int np, vl, no, ol;
        stats_t got, expa, expc;
        logic [7:0] pa[$] = '{8'd100, 8'd100};
        logic [7:0] pc[$] = '{8'd50};
        expa = model(pa);
        expc = model(pc);
        drive(1'b1, 8'd100, 1'b0); drive(1'b1, 8'd100, 1'b1);
        stim_q.push_back('{1'b0, 8'd0, 1'b0});
        stim_q.push_back('{1'b0, 8'd0, 1'b0});
        stim_q.push_back('{1'b0, 8'd0, 1'b0});
        stim_q.push_back('{1'b1, 8'd7, 1'b1});
        observe(14, np, vl, got, no, ol);
        nvec++;
        if (no !== 1 || ol !== 5) begin
            nmis++; $display("FAIL overrun_pulse: got %0d pulses first at cycle %0d, required 1 at cycle 5", no, ol);
        end
        nvec++;
        if (np !== 1 || vl !== 9 || got !== expa) begin
            nmis++; $display("FAIL overrun_keeps_A: got %s (pulses=%0d cyc=%0d), required %s at cycle 9", fmt(got), np, vl, fmt(expa));
        end
        drive(1'b1, 8'd50, 1'b1);
        observe(12, np, vl, got, no, ol);
        nvec++;
        if (np !== 1 || got !== expc || no !== 0) begin
            nmis++; $display("FAIL overrun_C_clean: got %s (pulses=%0d ovr=%0d), required %s", fmt(got), np, no, fmt(expc));
        end
    endtask

    task automatic test_coincident();
        int np, vl, no, ol;
        stats_t got, exp1, exp2;
        logic [7:0] p1[$] = '{8'd30, 8'd60};
        logic [7:0] p2[$] = '{8'd200, 8'd10};
        exp1 = model(p1);
        exp2 = model(p2);
        drive(1'b1, 8'd30, 1'b0); drive(1'b1, 8'd60, 1'b1);
        stim_q.push_back('{1'b1, 8'd200, 1'b0});
        observe(12, np, vl, got, no, ol);
        nvec++;
        if (np !== 1 || got !== exp1) begin
            nmis++; $display("FAIL coincident_end: got %s, required %s", fmt(got), fmt(exp1));
        end
        drive(1'b1, 8'd10, 1'b1);
        observe(12, np, vl, got, no, ol);
        nvec++;
        if (np !== 1 || got !== exp2) begin
            nmis++; $display("FAIL coincident_next: got %s, required %s", fmt(got), fmt(exp2));
        end
    endtask

    task automatic test_reset_mid_div();
        int np, vl, no, ol;
        stats_t got, exp;
        logic [7:0] px[$] = '{8'd80, 8'd90};
        exp = model(px);
        drive(1'b1, 8'd40, 1'b0); drive(1'b1, 8'd50, 1'b1);
        drive(1'b1, 8'd9, 1'b0); drive(1'b1, 8'd9, 1'b0); drive(1'b1, 8'd9, 1'b0);
        reset_n = 1'b0;
        #2;
        nvec++;
        if (cur() !== stats_t'('0) || stat_valid !== 1'b0 || overrun !== 1'b0) begin
            nmis++; $display("FAIL reset_async: got %s sv=%b, required all 0", fmt(cur()), stat_valid);
        end
        drive(1'b1, 8'd9, 1'b0); drive(1'b1, 8'd9, 1'b0);
        reset_n = 1'b1;
        observe(12, np, vl, got, no, ol);
        nvec++;
        if (np !== 0 || no !== 0 || cur() !== stats_t'('0)) begin
            nmis++; $display("FAIL reset_abort: got pulses=%0d ovr=%0d out %s, required none and all 0", np, no, fmt(cur()));
        end
        drive(1'b1, 8'd80, 1'b0); drive(1'b1, 8'd90, 1'b1);
        observe(12, np, vl, got, no, ol);
        nvec++;
        if (np !== 1 || vl !== 9 || got !== exp) begin
            nmis++; $display("FAIL reset_next_frame: got %s, required %s", fmt(got), fmt(exp));
        end
    endtask

    task automatic test_random();
        int np, vl, no, ol;
        stats_t got, exp;
        logic [7:0] px[$];
        bit coin;
        for (int f = 0; f < 12; f++) begin
            px.delete();
            for (int k = $urandom_range(0, 20); k > 0; k--) begin
                case ($urandom_range(0, 3))
                    0:       px.push_back(8'($urandom_range(0, 8)));
                    1:       px.push_back(8'($urandom_range(246, 255)));
                    default: px.push_back(8'($urandom_range(0, 255)));
                endcase
            end
            coin = ($urandom_range(0, 1) == 1);
            exp = model(px);
            send_frame(px, coin);
            observe(12, np, vl, got, no, ol);
            nvec++;
            if (np !== 1 || vl !== 9 || no !== 0 || got !== exp) begin
                nmis++;
                $display("FAIL random_frame%0d: got %s (pulses=%0d cyc=%0d ovr=%0d), required %s", f, fmt(got), np, vl, no, fmt(exp));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_bright_then_empty();
        test_overrun();
        test_coincident();
        test_reset_mid_div();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
